// File: rtl/mem_copy_engine.sv
// Block-move engine: copies Length bytes from SrcAddr to DstAddr over a single-port memory, one read + one write cycle per byte.
// Optional MEM_COPY_CHECKSUM_EN adds a running byte-sum output Checksum.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [LW-1:0] Length,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemAddress,
    output logic          MemWriteEn,
    output logic [DW-1:0] MemWrData,
    input  logic [DW-1:0] MemRdData
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] Checksum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hold_q, hold_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
                    cnt_d   = Length;
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (Length == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                hold_d  = MemRdData;
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(1);
                cnt_d   = cnt_q - LW'(1);
`ifdef MEM_COPY_CHECKSUM_EN
                csum_d  = csum_q + hold_q;
`endif
                state_d = (cnt_q == LW'(1)) ? S_DONE : S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write strobe is masked by Reset so an abort never lands a write on the reset edge.
    always_comb begin
        MemAddress = '0;
        case (state_q)
            S_RD:    MemAddress = src_q;
            S_WR:    MemAddress = dst_q;
            default: MemAddress = '0;
        endcase
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_DONE);
    assign MemWriteEn = (state_q == S_WR) && !Reset;
    assign MemWrData  = hold_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign Checksum   = csum_q;
`endif

endmodule
